// File: rtl/sram_mem_ctrl.sv
// MEM-stage data-memory controller: multi-beat, wait-stated access to a narrow external SRAM.
// Optional one-entry load buffer enabled by defining SRAM_CTRL_READ_BUF_EN.
module sram_mem_ctrl #(
   parameter int unsigned LEN         = 32,
   parameter int unsigned SRAM_DW     = 16,
   parameter int unsigned SRAM_AW     = 18,
   parameter int unsigned WAIT_CYCLES = 5,
   parameter int unsigned BASE_ADDR   = 1024
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               mem_r_en,
   input  logic               mem_w_en,
   input  logic [LEN-1:0]     address,
   input  logic [LEN-1:0]     wdata,
   output logic [LEN-1:0]     rdata,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [SRAM_DW-1:0] sram_dq_out,
   input  logic [SRAM_DW-1:0] sram_dq_in,
   output logic               sram_dq_oe,
   output logic               sram_we_n
);

   localparam int unsigned BEATS = LEN / SRAM_DW;
   localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned CW    = $clog2(WAIT_CYCLES);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
   localparam logic [CW-1:0] LAST_WAIT = CW'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        wait_q, wait_d;
   logic [BW-1:0]        beat_q, beat_d;
   logic [LEN-1:0]       word_q, word_d;
   logic [LEN-1:0]       data_q, data_d;
   logic                 write_q, write_d;
   logic [LEN-1:0]       rdata_q, rdata_d;
   logic [SRAM_AW-1:0]   addr_q, addr_d;
   logic [SRAM_DW-1:0]   dq_out_q, dq_out_d;
   logic                 oe_q, oe_d;
   logic                 we_n_q, we_n_d;

   logic [LEN-1:0]       req_word;
   logic                 hit;
   logic [LEN-1:0]       hit_data;
   logic                 complete;

   assign req_word = (address - LEN'(BASE_ADDR)) >> 2;
   assign complete = (state_q == ACCESS) && (wait_q == LAST_WAIT) && (beat_q == LAST_BEAT);

`ifdef SRAM_CTRL_READ_BUF_EN
   logic                 buf_valid_q, buf_valid_d;
   logic [LEN-1:0]       buf_tag_q, buf_tag_d;
   logic [LEN-1:0]       buf_data_q, buf_data_d;

   assign hit      = (state_q == IDLE) && mem_r_en && !mem_w_en && buf_valid_q &&
                     (req_word == buf_tag_q);
   assign hit_data = buf_data_q;

   // Loads fill the buffer; stores to the buffered word write through.
   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_tag_d   = buf_tag_q;
      buf_data_d  = buf_data_q;
      if (complete) begin
         if (!write_q) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = word_q;
            buf_data_d  = data_d;
         end else if (buf_valid_q && (word_q == buf_tag_q)) begin
            buf_data_d  = data_q;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         buf_valid_q <= 1'b0;
         buf_tag_q   <= '0;
         buf_data_q  <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_tag_q   <= buf_tag_d;
         buf_data_q  <= buf_data_d;
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_data = '0;
`endif

   assign rdata       = hit ? hit_data : rdata_q;
   assign sram_addr   = addr_q;
   assign sram_dq_out = dq_out_q;
   assign sram_dq_oe  = oe_q;
   assign sram_we_n   = we_n_q;

   // Next-state, counters and pipeline freeze.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      beat_d  = beat_q;
      word_d  = word_q;
      data_d  = data_q;
      write_d = write_q;
      rdata_d = rdata_q;
      ready   = 1'b1;
      case (state_q)
         IDLE: begin
            if (hit) begin
               rdata_d = hit_data;
            end else if (mem_r_en || mem_w_en) begin
               ready   = 1'b0;
               state_d = ACCESS;
               word_d  = req_word;
               write_d = mem_w_en;
               data_d  = mem_w_en ? wdata : '0;
               wait_d  = '0;
               beat_d  = '0;
            end
         end
         ACCESS: begin
            ready = 1'b0;
            if (wait_q == LAST_WAIT) begin
               if (!write_q) data_d[32'(beat_q)*SRAM_DW +: SRAM_DW] = sram_dq_in;
               wait_d = '0;
               if (beat_q == LAST_BEAT) begin
                  state_d = DONE;
                  beat_d  = '0;
                  if (!write_q) rdata_d = data_d;
               end else begin
                  beat_d = beat_q + BW'(1);
               end
            end else begin
               wait_d = wait_q + CW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (reset) ready = 1'b1;
   end

   // SRAM pins are registered, so they are derived from the upcoming state and counters.
   always_comb begin
      addr_d   = addr_q;
      dq_out_d = dq_out_q;
      oe_d     = 1'b0;
      we_n_d   = 1'b1;
      if (state_d == ACCESS) begin
         addr_d = SRAM_AW'(word_d * LEN'(BEATS) + LEN'(beat_d));
         oe_d   = write_d;
         we_n_d = !(write_d && (wait_d != LAST_WAIT));
         if (write_d) dq_out_d = data_d[32'(beat_d)*SRAM_DW +: SRAM_DW];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         wait_q   <= '0;
         beat_q   <= '0;
         word_q   <= '0;
         data_q   <= '0;
         write_q  <= 1'b0;
         rdata_q  <= '0;
         addr_q   <= '0;
         dq_out_q <= '0;
         oe_q     <= 1'b0;
         we_n_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         beat_q   <= beat_d;
         word_q   <= word_d;
         data_q   <= data_d;
         write_q  <= write_d;
         rdata_q  <= rdata_d;
         addr_q   <= addr_d;
         dq_out_q <= dq_out_d;
         oe_q     <= oe_d;
         we_n_q   <= we_n_d;
      end
   end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl with a small behavioural SRAM; covers the
// SRAM_CTRL_READ_BUF_EN build when that macro is defined.
module tb_sram_mem_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        mem_r_en, mem_w_en;
   logic [31:0] address, wdata, rdata;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
   logic        sram_dq_oe, sram_we_n;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:255];
   logic [17:0] log_addr [0:40];
   logic [15:0] log_dq   [0:40];
   logic        log_oe   [0:40];
   logic        log_we   [0:40];

   int          stall;
   logic [31:0] rd;
   logic [17:0] prev_addr;
   int          cnt;

   sram_mem_ctrl dut (
      .clock(clock), .reset(reset), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
      .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
   );

   always #5 clock = ~clock;

   always_ff @(posedge clock)
      if (!sram_we_n && sram_dq_oe) mem[sram_addr[7:0]] <= sram_dq_out;

   assign sram_dq_in = mem[sram_addr[7:0]];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Issue a request and hold it until ready is seen (DONE or buffer hit); log pins per cycle.
   task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, output int st, output logic [31:0] rdo);
      @(posedge clock); #1;
      mem_r_en = r; mem_w_en = w; address = a; wdata = wd;
      st = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         log_addr[i] = sram_addr; log_dq[i] = sram_dq_out;
         log_oe[i] = sram_dq_oe;  log_we[i] = sram_we_n;
         if (ready) break;
         st++;
      end
      rdo = rdata;
   endtask

   task automatic idle();
      @(posedge clock); #1;
      mem_r_en = 1'b0; mem_w_en = 1'b0;
      @(negedge clock);
   endtask

   function automatic int we_low(input int first, input int last);
      int n = 0;
      for (int i = first; i <= last; i++) if (!log_we[i]) n++;
      return n;
   endfunction

   initial begin
      reset = 1'b1; mem_r_en = 1'b1; mem_w_en = 1'b0; address = 32'd1032; wdata = '0;
      #2;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_we_n", 32'(sram_we_n), 32'd1);
      check("rst_oe", 32'(sram_dq_oe), 32'd0);
      check("rst_addr", 32'(sram_addr), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      mem_r_en = 1'b0;
      @(posedge clock); #1; reset = 1'b0;
      @(negedge clock);
      check("idle_ready", 32'(ready), 32'd1);

      // Make rdata non-zero before the mid-access reset.
      do_access(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, stall, rd);
      check("pre_st_stall", 32'(stall), 32'd11);
      idle();
      do_access(1'b1, 1'b0, 32'd1040, 32'h0, stall, rd);
      check("pre_ld_rdata", rd, 32'hCAFEF00D);
      idle();

      // Test 1: reset during beat 1 of a store.
      @(posedge clock); #1;
      mem_w_en = 1'b1; address = 32'd1040; wdata = 32'h11112222;
      repeat (7) @(negedge clock);
      check("t1_beat1_addr", 32'(sram_addr), 32'd9);
      check("t1_beat1_we", 32'(sram_we_n), 32'd0);
      #1 reset = 1'b1;
      #1;
      check("t1_we_n", 32'(sram_we_n), 32'd1);
      check("t1_oe", 32'(sram_dq_oe), 32'd0);
      check("t1_rdata", rdata, 32'd0);
      check("t1_ready", 32'(ready), 32'd1);
      mem_w_en = 1'b0;
      @(posedge clock); #1; reset = 1'b0;
      @(negedge clock);
      check("t1_idle_addr", 32'(sram_addr), 32'd0);

      // Test 2: store 0xDEADBEEF @1032.
      do_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, stall, rd);
      check("t2_stall", 32'(stall), 32'd11);
      check("t2_addr_b0", 32'(log_addr[1]), 32'd4);
      check("t2_addr_b1", 32'(log_addr[6]), 32'd5);
      check("t2_dq_b0", 32'(log_dq[1]), 32'h0000BEEF);
      check("t2_dq_b1", 32'(log_dq[6]), 32'h0000DEAD);
      check("t2_oe", 32'(log_oe[3]), 32'd1);
      check("t2_welow_b0", 32'(we_low(1, 5)), 32'd4);
      check("t2_welow_b1", 32'(we_low(6, 10)), 32'd4);
      check("t2_we_last", 32'(log_we[5]), 32'd1);
      check("t2_rdata", rd, 32'd0);
      check("t2_mem", {mem[5], mem[4]}, 32'hDEADBEEF);
      idle();

      // Test 3: load @1032.
      do_access(1'b1, 1'b0, 32'd1032, 32'h0, stall, rd);
      check("t3_stall", 32'(stall), 32'd11);
      cnt = 0;
      for (int i = 0; i <= 10; i++) if (log_oe[i]) cnt++;
      check("t3_oe", 32'(cnt), 32'd0);
      check("t3_we", 32'(we_low(0, 10)), 32'd0);
      check("t3_rdata", rd, 32'hDEADBEEF);
      idle();
      check("t3_rdata_hold", rdata, 32'hDEADBEEF);

      // Test 4: request held through DONE, then back-to-back load of the next word.
      do_access(1'b0, 1'b1, 32'd1036, 32'h44443333, stall, rd);
      idle();
      do_access(1'b1, 1'b0, 32'd1032, 32'h0, stall, rd);
      check("t4a_rdata", rd, 32'hDEADBEEF);
      do_access(1'b1, 1'b0, 32'd1036, 32'h0, stall, rd);
      check("t4b_stall", 32'(stall), 32'd11);
      check("t4b_addr_b0", 32'(log_addr[1]), 32'd6);
      check("t4b_addr_b1", 32'(log_addr[6]), 32'd7);
      check("t4b_rdata", rd, 32'h44443333);
      idle();

      // Test 5: both enables treated as a write.
      do_access(1'b1, 1'b1, 32'd1024, 32'h12345678, stall, rd);
      check("t5_stall", 32'(stall), 32'd11);
      check("t5_addr_b0", 32'(log_addr[1]), 32'd0);
      check("t5_addr_b1", 32'(log_addr[6]), 32'd1);
      check("t5_dq_b0", 32'(log_dq[1]), 32'h00005678);
      check("t5_dq_b1", 32'(log_dq[6]), 32'h00001234);
      check("t5_rdata", rd, 32'h44443333);
      check("t5_mem", {mem[1], mem[0]}, 32'h12345678);
      idle();

      // Test 6: repeated load of the same word, then store-through and reload.
      do_access(1'b1, 1'b0, 32'd1032, 32'h0, stall, rd);
      check("t6_fill_stall", 32'(stall), 32'd11);
      idle();
      prev_addr = sram_addr;
      do_access(1'b1, 1'b0, 32'd1032, 32'h0, stall, rd);
`ifdef SRAM_CTRL_READ_BUF_EN
      check("t6_hit_stall", 32'(stall), 32'd0);
      check("t6_hit_addr", 32'(log_addr[0]), 32'(prev_addr));
`else
      check("t6_rep_stall", 32'(stall), 32'd11);
`endif
      check("t6_hit_rdata", rd, 32'hDEADBEEF);
      idle();
      do_access(1'b0, 1'b1, 32'd1032, 32'h0, stall, rd);
      check("t6_st_stall", 32'(stall), 32'd11);
      check("t6_st_rdata", rd, 32'hDEADBEEF);
      idle();
      do_access(1'b1, 1'b0, 32'd1032, 32'hFFFFFFFF, stall, rd);
`ifdef SRAM_CTRL_READ_BUF_EN
      check("t6_wt_stall", 32'(stall), 32'd0);
`else
      check("t6_wt_stall", 32'(stall), 32'd11);
`endif
      check("t6_wt_rdata", rd, 32'd0);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
